// File: rtl/frame_dump_sequencer_if.sv
// Buffer read port and byte-UART write port of the frame dump sequencer.
// master: the sequencer side; slave: the frame buffer / UART side.
interface frame_dump_sequencer_if #(
    parameter int X_BITS = 6,
    parameter int Y_BITS = 5
);
    logic [X_BITS-1:0] read_x_o;
    logic [Y_BITS-1:0] read_y_o;
    logic [31:0]       read_q_i;
    logic [7:0]        uart_dat_o;
    logic              uart_wr_o;
    logic              uart_busy_i;

    modport master (
        output read_x_o,
        output read_y_o,
        input  read_q_i,
        output uart_dat_o,
        output uart_wr_o,
        input  uart_busy_i
    );

    modport slave (
        input  read_x_o,
        input  read_y_o,
        output read_q_i,
        input  uart_dat_o,
        input  uart_wr_o,
        output uart_busy_i
    );
endinterface

// File: rtl/frame_dump_sequencer.sv
// Streams the downsample frame buffer to a byte UART, one 32-bit word as 4 bytes MSB first.
// Optional macro FRAME_DUMP_HEADER_EN prefixes each dump with A5 5A <frame counter>.
module frame_dump_sequencer #(
    parameter int WIDTH        = 40,
    parameter int HEIGHT       = 30,
    parameter int X_BITS       = 6,
    parameter int Y_BITS       = 5,
    parameter int HOLDOFF_BITS = 13,
    parameter int READ_LAT     = 1
) (
    input  logic                   sys_clk_i,
    input  logic                   sys_rst_i,
    input  logic                   start_i,
    input  logic                   frame_sync_i,
    frame_dump_sequencer_if.master bus,
    output logic                   armed_o,
    output logic                   busy_o,
    output logic                   done_o
);
    localparam int LAT_BITS = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [X_BITS-1:0]   X_LAST   = X_BITS'(WIDTH - 1);
    localparam logic [Y_BITS-1:0]   Y_LAST   = Y_BITS'(HEIGHT - 1);
    localparam logic [LAT_BITS-1:0] LAT_LAST = LAT_BITS'(READ_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_FETCH   = 3'd2,
        ST_WAIT_RD = 3'd3,
        ST_SEND    = 3'd4,
        ST_DONE    = 3'd5
`ifdef FRAME_DUMP_HEADER_EN
        , ST_HDR   = 3'd6
`endif
    } state_t;

    state_t                  state_r, state_next_s;
    logic [X_BITS-1:0]       x_r;
    logic [Y_BITS-1:0]       y_r;
    logic [1:0]              lane_r;
    logic [31:0]             word_r;
    logic [LAT_BITS-1:0]     lat_r;
    logic [HOLDOFF_BITS-1:0] hold_r, hold_next_s;
    logic [7:0]              uart_dat_r, tx_byte_s;
    logic                    uart_wr_r, armed_r, busy_r, done_r;
    logic                    send_ok_s, strobe_s, last_word_s, lat_done_s;
`ifdef FRAME_DUMP_HEADER_EN
    logic [1:0]              hdr_idx_r;
    logic [7:0]              frame_cnt_r;

    function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [7:0] cnt);
        case (idx)
            2'd0:    hdr_byte = 8'hA5;
            2'd1:    hdr_byte = 8'h5A;
            default: hdr_byte = cnt;
        endcase
    endfunction
`endif

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] lane);
        case (lane)
            2'd0:    byte_sel = word[31:24];
            2'd1:    byte_sel = word[23:16];
            2'd2:    byte_sel = word[15:8];
            default: byte_sel = word[7:0];
        endcase
    endfunction

    // Holdoff: the strobe launches on the same edge the counter saturates, so the gap is exactly 2**HOLDOFF_BITS-1 idle cycles.
    always_comb begin
        hold_next_s = hold_r;
        if (bus.uart_busy_i) begin
            hold_next_s = {HOLDOFF_BITS{1'b0}};
        end else if (&hold_r) begin
            hold_next_s = hold_r;
        end else begin
            hold_next_s = hold_r + HOLDOFF_BITS'(1);
        end
    end

    assign send_ok_s   = (&hold_next_s) && !bus.uart_busy_i && !uart_wr_r;
    assign last_word_s = (x_r == X_LAST) && (y_r == Y_LAST);
    assign lat_done_s  = (lat_r == LAT_LAST);

    // Next-state and strobe decode.
    always_comb begin
        state_next_s = state_r;
        strobe_s     = 1'b0;
        tx_byte_s    = 8'h00;
        case (state_r)
            ST_IDLE: begin
                if (start_i) state_next_s = ST_ARMED;
                else         state_next_s = ST_IDLE;
            end
            ST_ARMED: begin
`ifdef FRAME_DUMP_HEADER_EN
                if (frame_sync_i) state_next_s = ST_HDR;
`else
                if (frame_sync_i) state_next_s = ST_FETCH;
`endif
                else              state_next_s = ST_ARMED;
            end
`ifdef FRAME_DUMP_HEADER_EN
            ST_HDR: begin
                if (send_ok_s) begin
                    strobe_s  = 1'b1;
                    tx_byte_s = hdr_byte(hdr_idx_r, frame_cnt_r);
                    if (hdr_idx_r == 2'd2) state_next_s = ST_FETCH;
                    else                   state_next_s = ST_HDR;
                end else begin
                    state_next_s = ST_HDR;
                end
            end
`endif
            ST_FETCH: state_next_s = ST_WAIT_RD;
            ST_WAIT_RD: begin
                if (lat_done_s) state_next_s = ST_SEND;
                else            state_next_s = ST_WAIT_RD;
            end
            ST_SEND: begin
                if (send_ok_s) begin
                    strobe_s  = 1'b1;
                    tx_byte_s = byte_sel(word_r, lane_r);
                    if (lane_r != 2'd3)   state_next_s = ST_SEND;
                    else if (last_word_s) state_next_s = ST_DONE;
                    else                  state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) state_r <= ST_IDLE;
        else           state_r <= state_next_s;
    end

    // Datapath: addresses, word latch, holdoff and registered outputs.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            x_r        <= {X_BITS{1'b0}};
            y_r        <= {Y_BITS{1'b0}};
            lane_r     <= 2'd0;
            word_r     <= 32'h0000_0000;
            lat_r      <= {LAT_BITS{1'b0}};
            hold_r     <= {HOLDOFF_BITS{1'b0}};
            uart_dat_r <= 8'h00;
            uart_wr_r  <= 1'b0;
            armed_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
`ifdef FRAME_DUMP_HEADER_EN
            hdr_idx_r   <= 2'd0;
            frame_cnt_r <= 8'h00;
`endif
        end else begin
            hold_r    <= hold_next_s;
            uart_wr_r <= strobe_s;
            if (strobe_s) uart_dat_r <= tx_byte_s;
            armed_r   <= (state_next_s == ST_ARMED);
            busy_r    <= (state_next_s != ST_IDLE) && (state_next_s != ST_ARMED);
            done_r    <= (state_next_s == ST_DONE);

            if (state_r == ST_ARMED && frame_sync_i) begin
                x_r    <= {X_BITS{1'b0}};
                y_r    <= {Y_BITS{1'b0}};
                lane_r <= 2'd0;
`ifdef FRAME_DUMP_HEADER_EN
                hdr_idx_r <= 2'd0;
`endif
            end

            if (state_r == ST_FETCH) begin
                lat_r <= {LAT_BITS{1'b0}};
            end else if (state_r == ST_WAIT_RD) begin
                lat_r <= lat_r + LAT_BITS'(1);
                if (lat_done_s) begin
                    word_r <= bus.read_q_i;
                    lane_r <= 2'd0;
                end
            end

            // The final word leaves x/y on the last address instead of wrapping.
            if (state_r == ST_SEND && strobe_s) begin
                lane_r <= lane_r + 2'd1;
                if (lane_r == 2'd3 && !last_word_s) begin
                    if (x_r == X_LAST) begin
                        x_r <= {X_BITS{1'b0}};
                        y_r <= y_r + Y_BITS'(1);
                    end else begin
                        x_r <= x_r + X_BITS'(1);
                    end
                end
            end

`ifdef FRAME_DUMP_HEADER_EN
            if (state_r == ST_HDR && strobe_s) hdr_idx_r <= hdr_idx_r + 2'd1;
            if (state_r == ST_DONE)            frame_cnt_r <= frame_cnt_r + 8'd1;
`endif
        end
    end

    assign bus.read_x_o   = x_r;
    assign bus.read_y_o   = y_r;
    assign bus.uart_dat_o = uart_dat_r;
    assign bus.uart_wr_o  = uart_wr_r;
    assign armed_o        = armed_r;
    assign busy_o         = busy_r;
    assign done_o         = done_r;
endmodule

// File: tb/tb_frame_dump_sequencer.sv
// Scoreboard bench for frame_dump_sequencer on a 2x2 buffer whose word at (x,y) is bytes {y,x,y,x}.
module tb_frame_dump_sequencer;
    localparam int WIDTH = 2, HEIGHT = 2, X_BITS = 1, Y_BITS = 1, HOLDOFF_BITS = 2, READ_LAT = 1;
    localparam int GAP = 3;
`ifdef FRAME_DUMP_HEADER_EN
    localparam int EXP_BYTES = 19;
`else
    localparam int EXP_BYTES = 16;
`endif
    localparam logic [7:0] DATA_BYTES [16] = '{
        8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h01, 8'h00, 8'h01,
        8'h01, 8'h00, 8'h01, 8'h00,
        8'h01, 8'h01, 8'h01, 8'h01
    };

    logic clk = 1'b0;
    logic sys_rst = 1'b1;
    logic start = 1'b0;
    logic frame_sync = 1'b0;
    logic armed_o, busy_o, done_o;

    frame_dump_sequencer_if #(.X_BITS(X_BITS), .Y_BITS(Y_BITS)) bus ();

    frame_dump_sequencer #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .X_BITS(X_BITS), .Y_BITS(Y_BITS),
        .HOLDOFF_BITS(HOLDOFF_BITS), .READ_LAT(READ_LAT)
    ) dut (
        .sys_clk_i(clk), .sys_rst_i(sys_rst), .start_i(start), .frame_sync_i(frame_sync),
        .bus(bus), .armed_o(armed_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int strobe_cnt = 0, done_cnt = 0, idle_run = 0, busy_cnt = 0;
    bit saw_busy = 1'b0, wr_prev = 1'b0, busy_mode = 1'b0;
    logic [7:0] exp_frame = 8'h00;
    logic [7:0] exp_q [$];
    logic [7:0] e;

    // Frame buffer with one cycle of read latency.
    always @(posedge clk)
        bus.read_q_i <= {7'd0, bus.read_y_o, 7'd0, bus.read_x_o, 7'd0, bus.read_y_o, 7'd0, bus.read_x_o};

    // UART model: busy for 20 cycles after each accepted strobe when enabled.
    always @(posedge clk) begin
        if (sys_rst || !busy_mode)  busy_cnt <= 0;
        else if (bus.uart_wr_o)     busy_cnt <= 20;
        else if (busy_cnt != 0)     busy_cnt <= busy_cnt - 1;
    end
    assign bus.uart_busy_i = (busy_cnt != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each strobe and checks pacing.
    always @(negedge clk) begin
        if (bus.uart_wr_o === 1'b1) begin
            strobe_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_byte: got %02h with no byte expected", bus.uart_dat_o);
            end else begin
                e = exp_q.pop_front();
                check("uart_byte", {24'd0, bus.uart_dat_o}, {24'd0, e});
            end
            check("no_adjacent_strobe", {31'd0, wr_prev}, 32'd0);
            if (busy_mode && saw_busy) check("holdoff_gap", idle_run, GAP);
            idle_run = 0;
            saw_busy = 1'b0;
        end else if (bus.uart_busy_i === 1'b1) begin
            saw_busy = 1'b1;
            idle_run = 0;
        end else begin
            idle_run++;
        end
        if (done_o === 1'b1) done_cnt++;
        wr_prev = (bus.uart_wr_o === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_sync();
        frame_sync = 1'b1;
        tick(1);
        frame_sync = 1'b0;
    endtask

    task automatic push_dump();
`ifdef FRAME_DUMP_HEADER_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(exp_frame);
`endif
        for (int i = 0; i < 16; i++) exp_q.push_back(DATA_BYTES[i]);
    endtask

    task automatic apply_reset();
        sys_rst = 1'b1;
        tick(2);
        sys_rst = 1'b0;
        exp_frame = 8'h00;
        exp_q.delete();
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (done_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        if (seen) exp_frame = exp_frame + 8'd1;
    endtask

    task automatic finish_dump(input string tag, input int sbase, input int dbase);
        tick(1);
        check({tag, "_busy_fall"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_done_one_cycle"}, {31'd0, done_o}, 32'd0);
        check({tag, "_bytes"}, strobe_cnt - sbase, EXP_BYTES);
        check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
        check({tag, "_done_pulses"}, done_cnt - dbase, 32'd1);
    endtask

    task automatic run_dump(input string tag, input int budget);
        int sbase, dbase;
        sbase = strobe_cnt;
        dbase = done_cnt;
        push_dump();
        pulse_start();
        check({tag, "_armed"}, {31'd0, armed_o}, 32'd1);
        tick(4);
        pulse_sync();
        wait_done(tag, budget);
        finish_dump(tag, sbase, dbase);
    endtask

    initial begin
        int sbase, dbase;
        bit seen;

        // Reset state
        tick(3);
        check("rst_armed", {31'd0, armed_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_wr", {31'd0, bus.uart_wr_o}, 32'd0);
        check("rst_dat", {24'd0, bus.uart_dat_o}, 32'd0);
        check("rst_xy", {30'd0, bus.read_y_o, bus.read_x_o}, 32'd0);
        sys_rst = 1'b0;
        tick(2);

        // 1: plain dump
        run_dump("s1", 500);
        tick(5);

        // 2: paced by a slow UART
        busy_mode = 1'b1;
        run_dump("s2", 3000);
        busy_mode = 1'b0;
        tick(25);

        // 3: frame_sync without arming, then start and frame_sync together
        sbase = strobe_cnt;
        pulse_sync();
        tick(10);
        check("s3_no_strobe", strobe_cnt - sbase, 32'd0);
        check("s3_not_busy", {31'd0, busy_o}, 32'd0);
        check("s3_not_armed", {31'd0, armed_o}, 32'd0);
        start = 1'b1;
        frame_sync = 1'b1;
        tick(1);
        start = 1'b0;
        frame_sync = 1'b0;
        check("s3_armed_only", {30'd0, armed_o, busy_o}, 32'd2);
        tick(5);
        check("s3_still_armed", {30'd0, armed_o, busy_o}, 32'd2);
        check("s3_no_strobe_armed", strobe_cnt - sbase, 32'd0);
        dbase = done_cnt;
        push_dump();
        pulse_sync();
        wait_done("s3", 500);
        finish_dump("s3", sbase, dbase);
        tick(5);

        // 4: reset after the sixth byte, then a fresh dump
        sbase = strobe_cnt;
        push_dump();
        pulse_start();
        tick(2);
        pulse_sync();
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (strobe_cnt - sbase >= 6) begin
                seen = 1'b1;
                break;
            end
            tick(1);
        end
        check("s4_six_bytes_seen", {31'd0, seen}, 32'd1);
        sys_rst = 1'b1;
        tick(1);
        check("s4_rst_outputs", {26'd0, armed_o, busy_o, done_o, bus.uart_wr_o, bus.read_y_o, bus.read_x_o}, 32'd0);
        check("s4_rst_dat", {24'd0, bus.uart_dat_o}, 32'd0);
        check("s4_bytes_before_rst", strobe_cnt - sbase, 32'd6);
        check("s4_left_in_queue", exp_q.size(), EXP_BYTES - 6);
        apply_reset();
        sbase = strobe_cnt;
        tick(30);
        check("s4_no_strobe_after_rst", strobe_cnt - sbase, 32'd0);
        check("s4_idle_after_rst", {30'd0, armed_o, busy_o}, 32'd0);
        run_dump("s4_rearm", 500);
        tick(5);

        // 5: stray start/frame_sync pulses during a dump
        sbase = strobe_cnt;
        dbase = done_cnt;
        push_dump();
        pulse_start();
        tick(4);
        pulse_sync();
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            start = (i == 3) || (i == 15);
            frame_sync = (i == 8) || (i == 22);
            tick(1);
            start = 1'b0;
            frame_sync = 1'b0;
            if (done_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("s5_done_seen", {31'd0, seen}, 32'd1);
        if (seen) exp_frame = exp_frame + 8'd1;
        finish_dump("s5", sbase, dbase);
        check("s5_not_rearmed", {31'd0, armed_o}, 32'd0);
        tick(5);

        // 6: two dumps after reset (frame counter 00 then 01 with the header)
        apply_reset();
        tick(2);
        run_dump("s6_first", 500);
        tick(3);
        run_dump("s6_second", 500);
        tick(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
